// File: rtl/sna_request_sequencer.sv
// Slave-side NoC adapter request sequencer: assembles one request from
// header/address/data flits, issues it on the AXI4-Lite master AW/W or AR
// channel, then waits for the response flow before accepting another.
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | waiting for a header flit
// ADDR        | header latched, waiting for the address flit
// DATA        | write request, waiting for the data flit
// ISSUE_WR    | AW and W valids driven until both handshakes complete
// ISSUE_RD    | AR valid driven until its handshake
// WAIT_RESP   | request issued, waiting for resp_done or timeout
module sna_request_sequencer #(
  parameter int RESP_TIMEOUT = 255,
  parameter int TIMEOUT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [36:0] noc_data,
  input  logic        noc_valid,
  output logic        noc_ready,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic        req_is_read,
  output logic [3:0]  req_pov_addr,
  output logic        req_issued,
  input  logic        resp_done,
  output logic        proto_err,
  output logic        resp_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ISSUE_WR,
    S_ISSUE_RD,
    S_WAIT_RESP
  } state_t;

  localparam logic [1:0] T_HDR  = 2'b10;
  localparam logic [1:0] T_ADDR = 2'b00;
  localparam logic [1:0] T_DATA = 2'b01;

  localparam logic [TIMEOUT_W-1:0] TO_VAL = TIMEOUT_W'(RESP_TIMEOUT);
  localparam bit TO_EN = (RESP_TIMEOUT != 0);

  state_t               state;
  logic [31:0]          addr;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 aw_done;
  logic                 w_done;

  logic [1:0] ftype;
  logic       flit_acc;
  logic       aw_hs;
  logic       w_hs;
  logic       ar_hs;
  logic       wr_complete;
  logic       timeout_hit;
  logic       unused_bits;

  assign ftype    = noc_data[36:35];
  assign flit_acc = noc_valid & noc_ready;
  assign aw_hs    = axi_awvalid & axi_awready;
  assign w_hs     = axi_wvalid & axi_wready;
  assign ar_hs    = axi_arvalid & axi_arready;

  // Both write channels finished: either earlier (flag) or in this cycle.
  assign wr_complete = (state == S_ISSUE_WR) & (aw_done | aw_hs) & (w_done | w_hs);
  assign req_issued  = wr_complete | ((state == S_ISSUE_RD) & ar_hs);

  // resp_done has priority over an expiring timer in the same cycle.
  assign timeout_hit = TO_EN && (state == S_WAIT_RESP) && (cnt == TO_VAL) && !resp_done;

  assign noc_ready = ~rst & ((state == S_IDLE) | (state == S_ADDR) | (state == S_DATA));

  assign axi_awaddr = addr;
  assign axi_araddr = addr;
  assign axi_wstrb  = 4'hF;

  assign unused_bits = ^noc_data[34:32];

  // Request FSM with registered valids, error/timeout pulses and latched fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      axi_wdata    <= '0;
      req_is_read  <= 1'b0;
      req_pov_addr <= '0;
      cnt          <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      axi_awvalid  <= 1'b0;
      axi_wvalid   <= 1'b0;
      axi_arvalid  <= 1'b0;
      proto_err    <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      proto_err    <= 1'b0;
      resp_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flit_acc) begin
            if (ftype == T_HDR) begin
              req_is_read  <= noc_data[0];
              req_pov_addr <= noc_data[27:24];
              state        <= S_ADDR;
            end else begin
              proto_err <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (flit_acc) begin
            if (ftype == T_ADDR) begin
              addr <= noc_data[31:0];
              if (req_is_read) begin
                axi_arvalid <= 1'b1;
                state       <= S_ISSUE_RD;
              end else begin
                state <= S_DATA;
              end
            end else if (ftype == T_HDR) begin
              req_is_read  <= noc_data[0];
              req_pov_addr <= noc_data[27:24];
              proto_err    <= 1'b1;
            end else begin
              proto_err <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (flit_acc) begin
            if (ftype == T_DATA) begin
              axi_wdata   <= noc_data[31:0];
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= S_ISSUE_WR;
            end else if (ftype == T_HDR) begin
              req_is_read  <= noc_data[0];
              req_pov_addr <= noc_data[27:24];
              proto_err    <= 1'b1;
              state        <= S_ADDR;
            end else begin
              proto_err <= 1'b1;
            end
          end
        end
        S_ISSUE_WR: begin
          if (aw_hs) begin
            axi_awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi_wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if (wr_complete) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            cnt     <= '0;
            state   <= S_WAIT_RESP;
          end
        end
        S_ISSUE_RD: begin
          if (ar_hs) begin
            axi_arvalid <= 1'b0;
            cnt         <= '0;
            state       <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          cnt <= cnt + 1'b1;
          if (resp_done) begin
            state <= S_IDLE;
          end else if (timeout_hit) begin
            resp_timeout <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
